// File: rtl/traffic_phase_sequencer_pkg.sv
// Shared types and command byte codes for the multi-approach traffic sequencer.
package traffic_pkg;

  typedef enum logic [1:0] {
    ST_ALL_RED = 2'd0,
    ST_GREEN   = 2'd1,
    ST_YELLOW  = 2'd2,
    ST_FLASH   = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    MODE_AUTO   = 2'd0,
    MODE_MANUAL = 2'd1,
    MODE_FLASH  = 2'd2
  } mode_e;

  // ASCII command bytes from the host stream
  localparam logic [7:0] CMD_AUTO   = 8'h41;  // 'A'
  localparam logic [7:0] CMD_MANUAL = 8'h4D;  // 'M'
  localparam logic [7:0] CMD_NEXT   = 8'h4E;  // 'N'
  localparam logic [7:0] CMD_FLASH  = 8'h46;  // 'F'

endpackage

// File: rtl/traffic_phase_sequencer_phase_timer.sv
// Phase down-counter: load has priority, counts on tick unless held,
// and flags the expiring tick when the count has reached zero.
module phase_timer #(
  parameter int               CNT_W   = 16,
  parameter logic [CNT_W-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             tick,
  input  logic             hold,
  output logic             done
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  assign done = tick && (cnt_q == '0) && !hold;

  // Next count: reload on phase entry, otherwise decrement on each unheld tick
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (tick && !hold && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  // Count register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= RST_VAL;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/traffic_phase_sequencer.sv
// Multi-approach traffic sequencer: timed green/yellow/all-red rotation with
// host-selectable auto, manual-step and flashing modes. Lamps are registered.
module traffic_phase_sequencer
  import traffic_pkg::*;
#(
  parameter int NUM_DIR      = 4,
  parameter int CNT_W        = 16,
  parameter int GREEN_TICKS  = 20,
  parameter int YELLOW_TICKS = 4,
  parameter int ALLRED_TICKS = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       tick,
  input  logic [7:0]                 command,
  input  logic                       command_valid,
  output logic [NUM_DIR-1:0]         red,
  output logic [NUM_DIR-1:0]         yellow,
  output logic [NUM_DIR-1:0]         green,
  output logic [$clog2(NUM_DIR)-1:0] active_dir,
  output logic [1:0]                 mode
);

  localparam int               DIR_W     = $clog2(NUM_DIR);
  localparam logic [DIR_W-1:0] LAST_DIR  = DIR_W'(NUM_DIR - 1);
  localparam logic [CNT_W-1:0] GREEN_LD  = CNT_W'(GREEN_TICKS - 1);
  localparam logic [CNT_W-1:0] YELLOW_LD = CNT_W'(YELLOW_TICKS - 1);
  localparam logic [CNT_W-1:0] ALLRED_LD = CNT_W'(ALLRED_TICKS - 1);

  state_e             state_q, state_d;
  mode_e              mode_q, mode_d;
  logic [DIR_W-1:0]   dir_q, dir_d;
  logic               flash_ph_q, flash_ph_d;
  // Set when all-red follows a yellow, so the next green moves to the next approach
  logic               adv_q, adv_d;
  logic [NUM_DIR-1:0] red_q, red_d, yellow_q, yellow_d, green_q, green_d;

  logic               cmd_act;
  logic               tmr_load;
  logic [CNT_W-1:0]   tmr_val;
  logic               tmr_hold;
  logic               tmr_done;

  assign tmr_hold = (mode_q == MODE_MANUAL) && (state_q == ST_GREEN);

  phase_timer #(
    .CNT_W   (CNT_W),
    .RST_VAL (ALLRED_LD)
  ) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load),
    .load_val (tmr_val),
    .tick     (tick),
    .hold     (tmr_hold),
    .done     (tmr_done)
  );

  // Next state: an accepted command overrides any timer expiry in the same cycle
  always_comb begin
    state_d    = state_q;
    mode_d     = mode_q;
    dir_d      = dir_q;
    flash_ph_d = flash_ph_q;
    adv_d      = adv_q;
    tmr_load   = 1'b0;
    tmr_val    = '0;
    cmd_act    = 1'b0;

    if (command_valid) begin
      case (command)
        CMD_AUTO, CMD_MANUAL: begin
          cmd_act = 1'b1;
          mode_d  = (command == CMD_AUTO) ? MODE_AUTO : MODE_MANUAL;
          if (state_q == ST_FLASH) begin
            state_d  = ST_ALL_RED;
            adv_d    = 1'b0;
            tmr_load = 1'b1;
            tmr_val  = ALLRED_LD;
          end else if ((command == CMD_AUTO) && (state_q == ST_GREEN)) begin
            tmr_load = 1'b1;
            tmr_val  = GREEN_LD;
          end
        end
        CMD_NEXT: begin
          if ((mode_q == MODE_MANUAL) && (state_q == ST_GREEN)) begin
            cmd_act  = 1'b1;
            state_d  = ST_YELLOW;
            tmr_load = 1'b1;
            tmr_val  = YELLOW_LD;
          end
        end
        CMD_FLASH: begin
          if (state_q != ST_FLASH) begin
            cmd_act    = 1'b1;
            state_d    = ST_FLASH;
            mode_d     = MODE_FLASH;
            flash_ph_d = 1'b1;
          end
        end
        default: ;
      endcase
    end

    if (!cmd_act) begin
      if (state_q == ST_FLASH) begin
        if (tick) begin
          flash_ph_d = !flash_ph_q;
        end
      end else if (tmr_done) begin
        case (state_q)
          ST_GREEN: begin
            state_d  = ST_YELLOW;
            tmr_load = 1'b1;
            tmr_val  = YELLOW_LD;
          end
          ST_YELLOW: begin
            state_d  = ST_ALL_RED;
            adv_d    = 1'b1;
            tmr_load = 1'b1;
            tmr_val  = ALLRED_LD;
          end
          ST_ALL_RED: begin
            state_d  = ST_GREEN;
            adv_d    = 1'b0;
            tmr_load = 1'b1;
            tmr_val  = GREEN_LD;
            if (adv_q) begin
              dir_d = (dir_q == LAST_DIR) ? '0 : dir_q + 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  // Lamp decode from next-state values so the lamps change with the state register
  always_comb begin
    red_d    = '1;
    yellow_d = '0;
    green_d  = '0;
    case (state_d)
      ST_GREEN: begin
        red_d[dir_d]   = 1'b0;
        green_d[dir_d] = 1'b1;
      end
      ST_YELLOW: begin
        red_d[dir_d]    = 1'b0;
        yellow_d[dir_d] = 1'b1;
      end
      ST_FLASH: begin
        red_d    = '0;
        yellow_d = {NUM_DIR{flash_ph_d}};
      end
      default: ;
    endcase
  end

  // State, control and lamp registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_ALL_RED;
      mode_q     <= MODE_AUTO;
      dir_q      <= '0;
      flash_ph_q <= 1'b0;
      adv_q      <= 1'b0;
      red_q      <= '1;
      yellow_q   <= '0;
      green_q    <= '0;
    end else begin
      state_q    <= state_d;
      mode_q     <= mode_d;
      dir_q      <= dir_d;
      flash_ph_q <= flash_ph_d;
      adv_q      <= adv_d;
      red_q      <= red_d;
      yellow_q   <= yellow_d;
      green_q    <= green_d;
    end
  end

  assign red        = red_q;
  assign yellow     = yellow_q;
  assign green      = green_q;
  assign active_dir = dir_q;
  assign mode       = mode_q;

endmodule

// File: tb/tb_traffic_phase_sequencer.sv
// Directed bench for traffic_phase_sequencer with hand-computed lamp patterns.
module tb_traffic_phase_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       tick;
  logic [7:0] command;
  logic       command_valid;
  logic [3:0] red, yellow, green;
  logic [1:0] active_dir;
  logic [1:0] mode;

  int checks = 0;
  int errors = 0;

  traffic_phase_sequencer dut (
    .clk           (clk),
    .rst           (rst),
    .tick          (tick),
    .command       (command),
    .command_valid (command_valid),
    .red           (red),
    .yellow        (yellow),
    .green         (green),
    .active_dir    (active_dir),
    .mode          (mode)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: drive inputs, take the edge, sample 1 ns later
  task automatic cyc(input logic t, input logic [7:0] c, input logic v);
    tick          = t;
    command       = c;
    command_valid = v;
    @(posedge clk);
    #1;
    tick          = 1'b0;
    command       = 8'h00;
    command_valid = 1'b0;
  endtask

  task automatic lamps(input string tag, input logic [3:0] r, input logic [3:0] y,
                       input logic [3:0] g);
    chk({tag, " red"}, red, r);
    chk({tag, " yellow"}, yellow, y);
    chk({tag, " green"}, green, g);
  endtask

  // n ticks; lamps must stay put for the first n-1, caller checks after the last
  task automatic hold_ticks(input int n, input string tag, input logic [3:0] r,
                            input logic [3:0] y, input logic [3:0] g);
    for (int i = 0; i < n - 1; i++) begin
      cyc(1'b1, 8'h00, 1'b0);
      lamps(tag, r, y, g);
    end
    cyc(1'b1, 8'h00, 1'b0);
  endtask

  // Auto rotation from the start of green on approach d to green on the next
  task automatic full_cycle(input int d);
    logic [3:0] g, gn;
    g  = 4'b0001 << d;
    gn = 4'b0001 << ((d + 1) % 4);
    hold_ticks(20, "green", ~g, 4'h0, g);
    lamps("to_yellow", ~g, g, 4'h0);
    hold_ticks(4, "yellow", ~g, g, 4'h0);
    lamps("to_allred", 4'hF, 4'h0, 4'h0);
    hold_ticks(2, "allred", 4'hF, 4'h0, 4'h0);
    lamps("to_green", ~gn, 4'h0, gn);
    chk("rot_dir", active_dir, (d + 1) % 4);
  endtask

  initial begin
    rst           = 1'b1;
    tick          = 1'b0;
    command       = 8'h00;
    command_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    lamps("reset", 4'hF, 4'h0, 4'h0);
    chk("reset_dir", active_dir, 0);
    chk("reset_mode", mode, 0);
    #3 rst = 1'b0;

    // Auto rotation through all four approaches and the wrap
    hold_ticks(2, "boot_allred", 4'hF, 4'h0, 4'h0);
    lamps("boot_green", 4'hE, 4'h0, 4'h1);
    chk("boot_dir", active_dir, 0);
    for (int d = 0; d < 4; d++) full_cycle(d);
    full_cycle(0);

    // Manual hold on approach 1, then step to approach 2
    cyc(1'b1, "M", 1'b1);
    chk("manual_mode", mode, 1);
    lamps("manual_g1", 4'hD, 4'h0, 4'h2);
    repeat (200) cyc(1'b1, 8'h00, 1'b0);
    lamps("manual_held", 4'hD, 4'h0, 4'h2);
    cyc(1'b0, "N", 1'b1);
    lamps("step_yellow", 4'hD, 4'h2, 4'h0);
    hold_ticks(4, "step_yellow", 4'hD, 4'h2, 4'h0);
    lamps("step_allred", 4'hF, 4'h0, 4'h0);
    hold_ticks(2, "step_allred", 4'hF, 4'h0, 4'h0);
    lamps("step_green", 4'hB, 4'h0, 4'h4);
    chk("step_dir", active_dir, 2);
    repeat (30) cyc(1'b1, 8'h00, 1'b0);
    lamps("step_held", 4'hB, 4'h0, 4'h4);

    // Ignored bytes: 'N' in manual yellow, 'Z'
    cyc(1'b0, "N", 1'b1);
    lamps("y2", 4'hB, 4'h4, 4'h0);
    cyc(1'b1, "N", 1'b1);
    lamps("n_in_yellow", 4'hB, 4'h4, 4'h0);
    chk("n_in_yellow_mode", mode, 1);
    cyc(1'b1, "Z", 1'b1);
    lamps("z_ignored", 4'hB, 4'h4, 4'h0);
    chk("z_mode", mode, 1);
    hold_ticks(2, "y2_tail", 4'hB, 4'h4, 4'h0);
    lamps("y2_allred", 4'hF, 4'h0, 4'h0);
    cyc(1'b0, "A", 1'b1);
    chk("auto_mode", mode, 0);
    lamps("auto_allred", 4'hF, 4'h0, 4'h0);
    hold_ticks(2, "ar3", 4'hF, 4'h0, 4'h0);
    lamps("g3", 4'h7, 4'h0, 4'h8);
    cyc(1'b0, "N", 1'b1);
    lamps("n_in_auto", 4'h7, 4'h0, 4'h8);
    chk("n_in_auto_mode", mode, 0);

    // Flash entered mid-yellow, then back to auto on the same approach
    hold_ticks(20, "g3", 4'h7, 4'h0, 4'h8);
    lamps("y3", 4'h7, 4'h8, 4'h0);
    cyc(1'b1, 8'h00, 1'b0);
    cyc(1'b0, "F", 1'b1);
    lamps("flash_on", 4'h0, 4'hF, 4'h0);
    chk("flash_mode", mode, 2);
    cyc(1'b1, 8'h00, 1'b0);
    lamps("flash_off", 4'h0, 4'h0, 4'h0);
    cyc(1'b1, 8'h00, 1'b0);
    lamps("flash_on2", 4'h0, 4'hF, 4'h0);
    cyc(1'b0, "F", 1'b1);
    lamps("flash_f_ignored", 4'h0, 4'hF, 4'h0);
    cyc(1'b0, "A", 1'b1);
    lamps("flash_exit", 4'hF, 4'h0, 4'h0);
    chk("flash_exit_mode", mode, 0);
    chk("flash_exit_dir", active_dir, 3);
    hold_ticks(2, "flash_allred", 4'hF, 4'h0, 4'h0);
    lamps("flash_green", 4'h7, 4'h0, 4'h8);
    chk("flash_green_dir", active_dir, 3);

    // 'M' on the green-expiring tick keeps green
    hold_ticks(19, "g3b", 4'h7, 4'h0, 4'h8);
    lamps("g3b_last", 4'h7, 4'h0, 4'h8);
    cyc(1'b1, "M", 1'b1);
    lamps("m_wins", 4'h7, 4'h0, 4'h8);
    chk("m_wins_mode", mode, 1);
    repeat (10) cyc(1'b1, 8'h00, 1'b0);
    lamps("m_wins_held", 4'h7, 4'h0, 4'h8);

    // Step manually to approach 2, go auto, then reset mid-green
    for (int k = 0; k < 3; k++) begin
      cyc(1'b0, "N", 1'b1);
      repeat (6) cyc(1'b1, 8'h00, 1'b0);
    end
    lamps("pre_rst", 4'hB, 4'h0, 4'h4);
    chk("pre_rst_dir", active_dir, 2);
    cyc(1'b0, "A", 1'b1);
    repeat (5) cyc(1'b1, 8'h00, 1'b0);
    lamps("mid_green", 4'hB, 4'h0, 4'h4);
    #2 rst = 1'b1;
    #1;
    lamps("async_rst", 4'hF, 4'h0, 4'h0);
    chk("async_rst_dir", active_dir, 0);
    chk("async_rst_mode", mode, 0);
    #2 rst = 1'b0;
    hold_ticks(2, "post_rst", 4'hF, 4'h0, 4'h0);
    lamps("post_rst_green", 4'hE, 4'h0, 4'h1);
    chk("post_rst_dir", active_dir, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/traffic_phase_sequencer.md
# traffic_phase_sequencer

Multi-approach traffic-light sequencer: timed green → yellow → all-red rotation across `NUM_DIR` approaches, with ASCII-command mode control (auto, manual step, flashing). Next generation of the single-head command-driven light controller. Sits between the system tick prescaler and the lamp-driver outputs; the host command byte stream is the same one the single-head controller uses.

## Interface
- `NUM_DIR`, 4: number of approaches, ≥2
- `CNT_W`, 16: phase-timer width
- `GREEN_TICKS`, 20: green duration in ticks, 1..2^CNT_W
- `YELLOW_TICKS`, 4: yellow duration in ticks, 1..2^CNT_W
- `ALLRED_TICKS`, 2: all-red clearance in ticks, 1..2^CNT_W
- `clk`  in  1  clock
- `rst`  in  1  reset, asynchronous, active-high
- `tick`  in  1  single-cycle timebase enable
- `command`  in  8  ASCII command byte
- `command_valid`  in  1  command qualifier, one command per valid cycle
- `red`  out  NUM_DIR  red lamp per approach
- `yellow`  out  NUM_DIR  yellow lamp per approach
- `green`  out  NUM_DIR  green lamp per approach
- `active_dir`  out  $clog2(NUM_DIR)  approach currently owning right-of-way
- `mode`  out  2  0 = AUTO, 1 = MANUAL, 2 = FLASH

## Operation
- States: ALL_RED, GREEN, YELLOW, FLASH.
- Reset: state ALL_RED, `active_dir` 0, `mode` AUTO, timer loaded `ALLRED_TICKS-1`, `red` all ones, `yellow`/`green` zero.
- Lamps: `green[active_dir]` = 1 in GREEN; `yellow[active_dir]` = 1 in YELLOW; all other approaches red. ALL_RED: all red. FLASH: red/green zero, all yellow = `flash_ph`.
- Exactly one lamp per approach is lit outside FLASH. Never more than one green.
- Timer: loaded with duration−1 on state entry; decrements on `tick`; phase ends on `tick` with timer == 0.
- AUTO: GREEN → YELLOW → ALL_RED → GREEN. `active_dir` increments at ALL_RED exit and wraps `NUM_DIR-1` → 0.
- MANUAL: GREEN holds indefinitely and the timer is frozen. 'N' in GREEN enters YELLOW. YELLOW and ALL_RED remain timed. After advance, the next approach holds green.
- Commands, acted on only with `command_valid`:
  - 'A': mode AUTO. If in GREEN, restart the green timer.
  - 'M': mode MANUAL.
  - 'N': ignored unless MANUAL and GREEN.
  - 'F': enter FLASH from any state; `flash_ph` = 1; toggles on each `tick`.
- Leaving FLASH ('A' or 'M'): enter ALL_RED with `active_dir` unchanged and full `ALLRED_TICKS`. This is the only exit from FLASH. 'F' while already in FLASH is ignored.
- All other bytes are ignored.

## Timing
- All outputs are registered. The state change is visible the cycle after the triggering `tick` or command.
- A timed phase lasts exactly duration ticks, counted from the first `tick` after entry.
- Command and expiring `tick` in the same cycle: the command wins. The timer event is discarded, and the new state loads its own duration.
- `tick` held high continuously is legal: every cycle counts.
- Reset mid-phase: immediate return to reset values, asynchronous; the next phase starts from approach 0.

## Structure
- Package `traffic_pkg`: state enum, mode enum, command constants "A", "M", "N", "F".
- Sub-module `phase_timer`:
  - `CNT_W` down-counter.
  - Inputs: `load`, `load_val`, `tick`, `hold`.
  - Output: `done` = tick & (cnt == 0) & !hold.
- Top level holds the FSM, `active_dir`, `flash_ph`, and the lamp decode.

## Test plan
- Reset, then `tick` every cycle with defaults. Required: 2 ticks all-red; `green` = 0001 for 20 ticks, `yellow` = 0001 for 4, all-red for 2; then `green` = 0010; after the 4th approach, wraps to 0001.
- 'M' during GREEN dir 1, then 200 ticks. Required: `green` = 0010 held. Then 'N'. Required: 4 yellow ticks, 2 red ticks, `green` = 0100 held.
- 'F' mid-YELLOW. Required: next cycle `yellow` = 1111, toggling each tick, `red` = `green` = 0. Then 'A'. Required: all red 2 ticks, then green on the same `active_dir`.
- 'N' in AUTO; 'Z'; 'N' in MANUAL YELLOW. Required: no state change for any of them.
- 'M' in the same cycle as the GREEN-expiring tick. Required: stays GREEN (held).
- `rst` pulse mid-GREEN dir 2. Required: immediate `red` = 1111, `active_dir` 0, `mode` AUTO.
